dmem_req_queue: RTL and testbench

DMEM_REQ_QUEUE -- requirements
Module: dmem_req_queue

---
 rtl/dmem_req_queue.sv | 121 ++++++++++++
 tb/tb_dmem_req_queue.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_req_queue.sv
// Data-memory request queue: strict FIFO between the core request port and the memory port.
// Optional same-cycle bypass on an empty queue is enabled by defining DMEM_REQ_QUEUE_BYPASS_EN.
module dmem_req_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         core_req_valid,
    output logic                         core_req_ready,
    input  logic [DATA_W-1:0]            core_req_wr_data,
    input  logic [ADDR_W-1:0]            core_req_address,
    input  logic                         core_req_wr_en,
    input  logic                         core_req_rd_en,
    input  logic [DATA_W/8-1:0]          core_req_byte_en,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [DATA_W-1:0]            mem_req_wr_data,
    output logic [ADDR_W-1:0]            mem_req_address,
    output logic                         mem_req_wr_en,
    output logic                         mem_req_rd_en,
    output logic [DATA_W/8-1:0]          mem_req_byte_en,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         err_illegal
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int BE_W    = DATA_W / 8;
    localparam int ENTRY_W = DATA_W + ADDR_W + 2 + BE_W;

    localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_DEPTH  = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               err_illegal_r;

    logic               legal_s;
    logic               push_s;
    logic               pop_s;
    logic               store_s;
    logic               bypass_s;
    logic [ENTRY_W-1:0] core_entry_s;
    logic [ENTRY_W-1:0] head_s;

    assign core_entry_s = {core_req_wr_data, core_req_address, core_req_wr_en,
                           core_req_rd_en, core_req_byte_en};
    assign full         = (count_r == CNT_DEPTH);
    assign empty        = (count_r == CNT_ZERO);
    assign count        = count_r;
    assign err_illegal  = err_illegal_r;
    assign {mem_req_wr_data, mem_req_address, mem_req_wr_en,
            mem_req_rd_en, mem_req_byte_en} = head_s;

    // Handshake qualification, head selection and store decision.
    always_comb begin
        legal_s        = core_req_wr_en ^ core_req_rd_en;
        core_req_ready = !full && !flush;
        push_s         = core_req_valid && core_req_ready;
`ifdef DMEM_REQ_QUEUE_BYPASS_EN
        bypass_s       = empty && !flush && core_req_valid && legal_s;
`else
        bypass_s       = 1'b0;
`endif
        mem_req_valid  = (!empty && !flush) || bypass_s;
        if (bypass_s) begin
            head_s = core_entry_s;
        end else begin
            head_s = mem_r[rd_ptr_r];
        end
        pop_s          = !empty && !flush && mem_req_ready;
        // Illegal requests are consumed but never stored; a bypassed request taken by memory is not stored either.
        store_s        = push_s && legal_s && !(bypass_s && mem_req_ready);
    end

    // Entry storage; intentionally not reset.
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem_r[wr_ptr_r] <= core_entry_s;
        end
    end

    // Pointers, occupancy and illegal-request pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            count_r       <= CNT_ZERO;
            err_illegal_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            count_r       <= CNT_ZERO;
            err_illegal_r <= 1'b0;
        end else begin
            if (store_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({store_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            err_illegal_r <= push_s && !legal_s;
        end
    end

endmodule

// File: tb/tb_dmem_req_queue.sv
// Self-checking bench for dmem_req_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model (honours DMEM_REQ_QUEUE_BYPASS_EN).
module tb_dmem_req_queue;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);
`ifdef DMEM_REQ_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [DATA_W-1:0]   d;
        logic [ADDR_W-1:0]   a;
        logic                w;
        logic                r;
        logic [DATA_W/8-1:0] be;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic core_req_valid = 1'b0;
    logic core_req_ready;
    logic [DATA_W-1:0] core_req_wr_data = '0;
    logic [ADDR_W-1:0] core_req_address = '0;
    logic core_req_wr_en = 1'b0;
    logic core_req_rd_en = 1'b0;
    logic [DATA_W/8-1:0] core_req_byte_en = '0;
    logic mem_req_valid;
    logic mem_req_ready = 1'b0;
    logic [DATA_W-1:0] mem_req_wr_data;
    logic [ADDR_W-1:0] mem_req_address;
    logic mem_req_wr_en;
    logic mem_req_rd_en;
    logic [DATA_W/8-1:0] mem_req_byte_en;
    logic [CW-1:0] count;
    logic full;
    logic empty;
    logic err_illegal;

    req_t q[$];
    bit   exp_err = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    dmem_req_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_wr_data(core_req_wr_data), .core_req_address(core_req_address),
        .core_req_wr_en(core_req_wr_en), .core_req_rd_en(core_req_rd_en),
        .core_req_byte_en(core_req_byte_en),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wr_data(mem_req_wr_data), .mem_req_address(mem_req_address),
        .mem_req_wr_en(mem_req_wr_en), .mem_req_rd_en(mem_req_rd_en),
        .mem_req_byte_en(mem_req_byte_en),
        .count(count), .full(full), .empty(empty), .err_illegal(err_illegal)
    );

    function automatic bit legal();
        return core_req_wr_en != core_req_rd_en;
    endfunction

    function automatic req_t cur_req();
        return '{d: core_req_wr_data, a: core_req_address, w: core_req_wr_en,
                 r: core_req_rd_en, be: core_req_byte_en};
    endfunction

    function automatic bit exp_ready();
        return (q.size() < DEPTH) && !flush;
    endfunction

    function automatic bit byp_now();
        return BYP && (q.size() == 0) && !flush && core_req_valid && legal();
    endfunction

    function automatic bit exp_valid();
        return ((q.size() > 0) && !flush) || byp_now();
    endfunction

    function automatic req_t exp_head();
        if (q.size() > 0) return q[0];
        return cur_req();
    endfunction

    // Reference model update for one rising edge, from the current inputs.
    task automatic model_edge();
        bit push, pop, taken;
        push  = core_req_valid && exp_ready();
        pop   = exp_valid() && mem_req_ready;
        taken = byp_now() && mem_req_ready;
        exp_err = push && !legal();
        if (flush) begin
            q.delete();
        end else begin
            if (pop && q.size() > 0) void'(q.pop_front());
            if (push && legal() && !taken) q.push_back(cur_req());
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_req(input bit v, input logic [ADDR_W-1:0] a, input bit w, input bit r);
        core_req_valid   = v;
        core_req_address = a;
        core_req_wr_en   = w;
        core_req_rd_en   = r;
        core_req_wr_data = $urandom;
        core_req_byte_en = 4'($urandom_range(0, 15));
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({count, empty, full, mem_req_valid, err_illegal} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL reset_state: got cnt=%0d e=%b f=%b v=%b err=%b, expected cnt=0 e=1 f=0 v=0 err=0",
                     count, empty, full, mem_req_valid, err_illegal);
            fails++;
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        q.delete();
        exp_err = 1'b0;
        #1;
        tests++;
        if (core_req_ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b expected 1", core_req_ready);
            fails++;
        end
    endtask

    task automatic test_fill();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, ADDR_W'(32'h10 + 4 * i), 1'b1, 1'b0);
            cyc();
        end
        set_req(1'b1, 32'h99, 1'b1, 1'b0);
        #1;
        tests++;
        if ({full, core_req_ready, count, mem_req_valid, mem_req_address} !== {1'b1, 1'b0, 3'd4, 1'b1, 32'h10}) begin
            $display("FAIL fill_state: got f=%b rdy=%b cnt=%0d v=%b addr=%h, expected f=1 rdy=0 cnt=4 v=1 addr=10",
                     full, core_req_ready, count, mem_req_valid, mem_req_address);
            fails++;
        end
        cyc();
        cyc();
        tests++;
        if ({count, mem_req_address} !== {3'd4, 32'h10}) begin
            $display("FAIL fill_hold: got cnt=%0d addr=%h, expected cnt=4 addr=10", count, mem_req_address);
            fails++;
        end
    endtask

    task automatic test_drain_refill();
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, ADDR_W'(32'h20 + 4 * i), 1'b1, 1'b0);
            #1;
            tests++;
            if ({mem_req_valid, mem_req_address, count} !== {1'b1, ADDR_W'(32'h10 + 4 * i), CW'(i == 0 ? 4 : 3)}) begin
                $display("FAIL drain_step%0d: got v=%b addr=%h cnt=%0d, expected v=1 addr=%h cnt=%0d",
                         i, mem_req_valid, mem_req_address, count, 32'h10 + 4 * i, (i == 0 ? 4 : 3));
                fails++;
            end
            cyc();
        end
        core_req_valid = 1'b0;
        #1;
        tests++;
        if ({count, mem_req_address} !== {3'd3, 32'h24}) begin
            $display("FAIL refill_wrap: got cnt=%0d addr=%h, expected cnt=3 addr=24", count, mem_req_address);
            fails++;
        end
        for (int i = 0; i < 8 && q.size() > 0; i++) cyc();
        tests++;
        if ({count, empty} !== {3'd0, 1'b1}) begin
            $display("FAIL drain_empty: got cnt=%0d e=%b, expected cnt=0 e=1", count, empty);
            fails++;
        end
    endtask

    task automatic test_illegal();
        mem_req_ready = 1'b0;
        set_req(1'b1, 32'h30, 1'b1, 1'b1);
        #1;
        tests++;
        if ({core_req_ready, err_illegal} !== {1'b1, 1'b0}) begin
            $display("FAIL illegal_accept: got rdy=%b err=%b, expected rdy=1 err=0", core_req_ready, err_illegal);
            fails++;
        end
        cyc();
        core_req_valid = 1'b0;
        #1;
        tests++;
        if ({err_illegal, count} !== {1'b1, 3'd0}) begin
            $display("FAIL illegal_pulse: got err=%b cnt=%0d, expected err=1 cnt=0", err_illegal, count);
            fails++;
        end
        cyc();
        tests++;
        if (err_illegal !== 1'b0) begin
            $display("FAIL illegal_once: got err=%b expected 0", err_illegal);
            fails++;
        end
    endtask

    task automatic test_flush();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, ADDR_W'(32'h50 + 4 * i), 1'b0, 1'b1);
            cyc();
        end
        flush = 1'b1;
        set_req(1'b1, 32'h60, 1'b1, 1'b0);
        #1;
        tests++;
        if ({count, core_req_ready, mem_req_valid} !== {3'd3, 1'b0, 1'b0}) begin
            $display("FAIL flush_cycle: got cnt=%0d rdy=%b v=%b, expected cnt=3 rdy=0 v=0",
                     count, core_req_ready, mem_req_valid);
            fails++;
        end
        cyc();
        flush = 1'b0;
        core_req_valid = 1'b0;
        #1;
        tests++;
        if ({count, mem_req_valid, empty} !== {3'd0, 1'b0, 1'b1}) begin
            $display("FAIL flush_after: got cnt=%0d v=%b e=%b, expected cnt=0 v=0 e=1", count, mem_req_valid, empty);
            fails++;
        end
    endtask

    task automatic test_bypass();
        mem_req_ready = 1'b1;
        set_req(1'b1, 32'h40, 1'b0, 1'b1);
        #1;
        tests++;
        if ({mem_req_valid, (BYP ? mem_req_address : 32'h40)} !== {BYP, 32'h40}) begin
            $display("FAIL bypass_same: got v=%b addr=%h, expected v=%b addr=40", mem_req_valid, mem_req_address, BYP);
            fails++;
        end
        cyc();
        core_req_valid = 1'b0;
        #1;
        tests++;
        if ({count, mem_req_valid, (BYP ? 32'h40 : mem_req_address)} !== {CW'(!BYP), !BYP, 32'h40}) begin
            $display("FAIL bypass_next: got cnt=%0d v=%b addr=%h, expected cnt=%0d v=%b addr=40",
                     count, mem_req_valid, mem_req_address, !BYP, !BYP);
            fails++;
        end
        cyc();
    endtask

    task automatic test_async_reset();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_req(1'b1, ADDR_W'(32'h70 + 4 * i), 1'b1, 1'b0);
            cyc();
        end
        core_req_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({mem_req_valid, count, empty} !== {1'b0, 3'd0, 1'b1}) begin
            $display("FAIL async_reset: got v=%b cnt=%0d e=%b, expected v=0 cnt=0 e=1", mem_req_valid, count, empty);
            fails++;
        end
        @(posedge clk);
        #2 rst = 1'b0;
        q.delete();
        exp_err = 1'b0;
        #1;
    endtask

    task automatic test_random();
        logic [7:0] act_v, exp_v;
        int sel;
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 7);
            flush = ($urandom_range(0, 19) == 0);
            set_req($urandom_range(0, 1) == 1, $urandom,
                    sel == 0 ? 1'b1 : (sel == 1 ? 1'b0 : sel[0]),
                    sel == 0 ? 1'b1 : (sel == 1 ? 1'b0 : !sel[0]));
            mem_req_ready = ($urandom_range(0, 2) != 0);
            #1;
            act_v = {core_req_ready, mem_req_valid, count, full, empty, err_illegal};
            exp_v = {exp_ready(), exp_valid(), CW'(q.size()), q.size() == DEPTH, q.size() == 0, exp_err};
            tests++;
            if (act_v !== exp_v) begin
                $display("FAIL rand_ctl[%0d]: got rdy,v,cnt,f,e,err=%b expected %b", n, act_v, exp_v);
                fails++;
            end
            if (exp_valid()) begin
                tests++;
                if ({mem_req_wr_data, mem_req_address, mem_req_wr_en, mem_req_rd_en, mem_req_byte_en} !== exp_head()) begin
                    $display("FAIL rand_head[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                             n, mem_req_address, mem_req_wr_data, exp_head().a, exp_head().d);
                    fails++;
                end
            end
            cyc();
        end
        flush = 1'b0;
        core_req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_refill();
        test_illegal();
        test_flush();
        test_bypass();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
